// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Registered branch/jump resolution with prediction check and a
//            valid/ready output stage. Optional statistics counters are
//            enabled by defining BRANCH_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op_kind,
    input  logic [2:0]        branch_control,
    input  logic [XLEN-1:0]   rd1,
    input  logic [XLEN-1:0]   rd2,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic              pred_taken,
    input  logic [XLEN-1:0]   pred_target,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              taken,
    output logic [XLEN-1:0]   target,
    output logic [XLEN-1:0]   link,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_branches,
    output logic [CNT_W-1:0]  stat_mispredicts
`endif
);

    localparam logic [1:0]      c_OP_BRANCH = 2'b00;
    localparam logic [1:0]      c_OP_JAL    = 2'b01;
    localparam logic [1:0]      c_OP_JALR   = 2'b10;
    localparam logic [XLEN-1:0] c_FOUR      = XLEN'(4);
    localparam logic [XLEN-1:0] c_ONE       = XLEN'(1);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("branch_resolve_unit: XLEN must be 32 or 64");
    end

    logic              valid_q, valid_d;
    logic              taken_q, taken_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic [XLEN-1:0]   link_q, link_d;
    logic              mis_q, mis_d;
    logic [XLEN-1:0]   redir_q, redir_d;
    logic              ill_q, ill_d;

    logic              w_accept;
    logic              w_load;
    logic              w_eq, w_lt, w_ltu;
    logic [XLEN-1:0]   w_br_tgt, w_jalr_sum;

    assign in_ready   = !valid_q || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_load     = w_accept && !flush;

    assign w_eq       = (rd1 == rd2);
    assign w_lt       = ($signed(rd1) < $signed(rd2));
    assign w_ltu      = (rd1 < rd2);
    assign w_br_tgt   = pc + imm;
    assign w_jalr_sum = rd1 + imm;

    always_comb begin
        taken_d  = 1'b0;
        ill_d    = 1'b0;
        target_d = w_br_tgt;
        link_d   = pc + c_FOUR;
        case (op_kind)
            c_OP_BRANCH: begin
                case (branch_control)
                    3'b000:  taken_d = w_eq;
                    3'b001:  taken_d = !w_eq;
                    3'b100:  taken_d = w_lt;
                    3'b101:  taken_d = !w_lt;
                    3'b110:  taken_d = w_ltu;
                    3'b111:  taken_d = !w_ltu;
                    default: ill_d   = 1'b1;
                endcase
            end
            c_OP_JAL:  taken_d = 1'b1;
            c_OP_JALR: begin
                taken_d  = 1'b1;
                target_d = w_jalr_sum & ~c_ONE;
            end
            default:   ill_d = 1'b1;
        endcase
        // Illegal encodings resolve not-taken, so they mispredict exactly when predicted taken.
        mis_d   = (taken_d != pred_taken) || (taken_d && (target_d != pred_target));
        redir_d = taken_d ? target_d : link_d;
    end

    assign valid_d = !flush && (w_accept || (valid_q && !out_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            link_q   <= '0;
            mis_q    <= 1'b0;
            redir_q  <= '0;
            ill_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (w_load) begin
                taken_q  <= taken_d;
                target_q <= target_d;
                link_q   <= link_d;
                mis_q    <= mis_d;
                redir_q  <= redir_d;
                ill_q    <= ill_d;
            end
        end
    end

    assign out_valid   = valid_q;
    assign taken       = taken_q;
    assign target      = target_q;
    assign link        = link_q;
    assign mispredict  = mis_q;
    assign redirect_pc = redir_q;
    assign illegal     = ill_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mis_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else if (w_load) begin
            if (op_kind == c_OP_BRANCH && br_cnt_q != {CNT_W{1'b1}}) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (mis_d && mis_cnt_q != {CNT_W{1'b1}}) begin
                mis_cnt_q <= mis_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mis_cnt_q;
`else
    if (CNT_W < 1) begin : g_bad_cnt
        $error("branch_resolve_unit: CNT_W must be positive");
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed and randomized checks of branch_resolve_unit against a
//            behavioural reference model (stats checks when BRANCH_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        op_kind = '0;
    logic [2:0]        branch_control = '0;
    logic [XLEN-1:0]   rd1 = '0, rd2 = '0, pc = '0, imm = '0, pred_target = '0;
    logic              pred_taken = 1'b0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              taken, mispredict, illegal;
    logic [XLEN-1:0]   target, link, redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0]  stat_branches, stat_mispredicts;
`endif

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_kind(op_kind), .branch_control(branch_control),
        .rd1(rd1), .rd2(rd2), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
        .target(target), .link(link), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .illegal(illegal)
`ifdef BRANCH_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            taken;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] link;
        logic            mis;
        logic [XLEN-1:0] redir;
        logic            ill;
    } res_t;

    res_t        sb[$];
    int unsigned m_br = 0, m_mis = 0;
    int          checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed order obtained by flipping the sign bit and comparing unsigned.
    function automatic res_t model(input logic [1:0] op, input logic [2:0] bc,
                                   input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
                                   input logic pt, input logic [XLEN-1:0] ptg);
        res_t r;
        logic [XLEN-1:0] bias, sum;
        bias     = {1'b1, {(XLEN-1){1'b0}}};
        r.link   = p + 4;
        r.target = p + im;
        r.taken  = 1'b0;
        r.ill    = 1'b0;
        if (op == 2'd0) begin
            case (bc)
                3'd0: r.taken = (a == b);
                3'd1: r.taken = (a != b);
                3'd4: r.taken = ((a ^ bias) < (b ^ bias));
                3'd5: r.taken = ((a ^ bias) >= (b ^ bias));
                3'd6: r.taken = (a < b);
                3'd7: r.taken = (a >= b);
                default: r.ill = 1'b1;
            endcase
        end else if (op == 2'd1) begin
            r.taken = 1'b1;
        end else if (op == 2'd2) begin
            r.taken  = 1'b1;
            sum      = a + im;
            r.target = {sum[XLEN-1:1], 1'b0};
        end else begin
            r.ill = 1'b1;
        end
        r.mis   = (r.taken != pt) || (r.taken && r.target != ptg);
        r.redir = r.taken ? r.target : r.link;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] bc,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
                         input logic pt, input logic [XLEN-1:0] ptg);
        in_valid = v; op_kind = op; branch_control = bc;
        rd1 = a; rd2 = b; pc = p; imm = im; pred_taken = pt; pred_target = ptg;
    endtask

    // One clock: check state at the negedge, then advance the model past the posedge.
    task automatic step();
        logic acc, drn, fl, is_br;
        res_t r;
        @(negedge clk);
        chk("in_ready", in_ready, (sb.size() == 0) || out_ready);
        chk("out_valid", out_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            chk("taken", taken, sb[0].taken);
            chk("target", target, sb[0].target);
            chk("link", link, sb[0].link);
            chk("mispredict", mispredict, sb[0].mis);
            chk("redirect_pc", redirect_pc, sb[0].redir);
            chk("illegal", illegal, sb[0].ill);
        end
        acc   = in_valid && ((sb.size() == 0) || out_ready);
        drn   = (sb.size() != 0) && out_ready;
        fl    = flush;
        is_br = (op_kind == 2'd0);
        r     = model(op_kind, branch_control, rd1, rd2, pc, imm, pred_taken, pred_target);
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (drn) void'(sb.pop_front());
            if (acc) begin
                sb.push_back(r);
                if (is_br && m_br < CNT_MAX) m_br++;
                if (r.mis && m_mis < CNT_MAX) m_mis++;
            end
        end
`ifdef BRANCH_STATS_EN
        chk("stat_branches", stat_branches, m_br);
        chk("stat_mispredicts", stat_mispredicts, m_mis);
`endif
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] bc,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
                         input logic pt, input logic [XLEN-1:0] ptg);
        drive(1'b1, op, bc, a, b, p, im, pt, ptg);
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_taken", taken, 0);
        chk("rst_target", target, 0);
        chk("rst_link", link, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef BRANCH_STATS_EN
        chk("rst_stat_br", stat_branches, 0);
        chk("rst_stat_mis", stat_mispredicts, 0);
`endif
        sb.delete();
        m_br  = 0;
        m_mis = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [XLEN-1:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return XLEN'($urandom_range(0, 8));
            1:       return '1 - XLEN'($urandom_range(0, 8));
            default: return XLEN'({$urandom, $urandom});
        endcase
    endfunction

    initial begin
        #1;
        do_reset();

        // Signed/unsigned compares
        issue(2'd0, 3'b100, 32'hFFFF_FF9C, 32'hFFFF_FF38, 32'h100, 32'h20, 1'b0, '0);
        chk("blt_neg_taken", taken, 0);
        issue(2'd0, 3'b110, 32'hFFFF_FF9C, 32'hFFFF_FF38, 32'h100, 32'h20, 1'b0, '0);
        chk("bltu_neg_taken", taken, 0);
        issue(2'd0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, '0);
        chk("blt_m1_taken", taken, 1);
        issue(2'd0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, '0);
        chk("bltu_m1_taken", taken, 0);

        // JALR target/link/mispredict
        issue(2'd2, 3'b000, 32'h1001, '0, 32'h200, 32'h10, 1'b1, 32'h1010);
        chk("jalr_target", target, 32'h1010);
        chk("jalr_link", link, 32'h204);
        chk("jalr_mis", mispredict, 0);
        issue(2'd2, 3'b000, 32'h1001, '0, 32'h200, 32'h10, 1'b1, 32'h1011);
        chk("jalr_mis2", mispredict, 1);
        chk("jalr_redir2", redirect_pc, 32'h1010);

        // Illegal encodings
        issue(2'd0, 3'b010, 32'h5, 32'h5, 32'h40, 32'h80, 1'b1, 32'hC0);
        chk("ill_flag", illegal, 1);
        chk("ill_taken", taken, 0);
        chk("ill_mis", mispredict, 1);
        chk("ill_redir", redirect_pc, 32'h44);
        issue(2'd3, 3'b000, 32'h5, 32'h5, 32'h40, 32'h80, 1'b0, 32'hC0);
        chk("ill_op3", illegal, 1);

        // Back-pressure: three BEQs while the consumer stalls
        drive(1'b0, 2'd0, 3'b000, '0, '0, '0, '0, 1'b0, '0);
        step();
        out_ready = 1'b0;
        issue(2'd0, 3'b000, 32'h7, 32'h7, 32'h100, 32'h40, 1'b1, 32'h140);
        drive(1'b1, 2'd0, 3'b000, 32'h7, 32'h8, 32'h110, 32'h40, 1'b0, '0);
        step();
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_link", link, 32'h104);
        step();
        chk("bp_hold_link2", link, 32'h104);
        chk("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        chk("bp_second_link", link, 32'h114);
        issue(2'd0, 3'b000, 32'h9, 32'h9, 32'h120, 32'h40, 1'b1, 32'h160);
        chk("bp_third_link", link, 32'h124);
        drive(1'b0, 2'd0, 3'b000, '0, '0, '0, '0, 1'b0, '0);
        step();
        chk("bp_drained", out_valid, 0);

        // Flush coincident with accept while full
        issue(2'd1, 3'b000, '0, '0, 32'h300, 32'h8, 1'b1, 32'h308);
        flush = 1'b1;
        issue(2'd1, 3'b000, '0, '0, 32'h400, 32'h8, 1'b1, 32'h408);
        chk("flush_valid", out_valid, 0);
        flush = 1'b0;
        drive(1'b0, 2'd0, 3'b000, '0, '0, '0, '0, 1'b0, '0);
        step();

        // Asynchronous reset mid-stream
        issue(2'd1, 3'b000, '0, '0, 32'h500, 32'h8, 1'b0, '0);
        drive(1'b0, 2'd0, 3'b000, '0, '0, '0, '0, 1'b0, '0);
        #2;
        do_reset();
        step();

`ifdef BRANCH_STATS_EN
        for (int i = 0; i < 20; i++) begin
            issue(2'd0, 3'b001, XLEN'(i), XLEN'(i + 1), XLEN'(32'h600 + 4 * i), 32'h10, 1'b0, '0);
        end
        drive(1'b0, 2'd0, 3'b000, '0, '0, '0, '0, 1'b0, '0);
        step();
        chk("stat_br_sat", stat_branches, 15);
        chk("stat_mis_sat", stat_mispredicts, 15);
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [XLEN-1:0] a, b, p, im, ptg;
            logic [1:0]      op;
            logic [2:0]      bc;
            a   = rnd_val();
            b   = ($urandom_range(0, 3) == 0) ? a : rnd_val();
            p   = XLEN'({$urandom, $urandom});
            im  = rnd_val();
            op  = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            bc  = 3'($urandom);
            ptg = ($urandom_range(0, 2) == 0) ? XLEN'({$urandom, $urandom}) : p + im;
            drive($urandom_range(0, 3) != 0, op, bc, a, b, p, im, 1'($urandom), ptg);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'd0, 3'b000, '0, '0, '0, '0, 1'b0, '0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
